// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - sequences an operand pair through an external bit-serial adder
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_clr,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             ser_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;

  // Incoming sum bit enters at the MSB; after WIDTH shifts bit k sits at position k.
  assign acc_nxt = WIDTH'({ser_sum, acc} >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_clr   = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CLEAR;
      end
      CLEAR: begin
        ser_clr   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ser_a/ser_b are preloaded during CLEAR so bit k is on the wire for the whole SHIFT cycle k.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_a    <= '0;
      sh_b    <= '0;
      acc     <= '0;
      cnt     <= '0;
      ser_a   <= 1'b0;
      ser_b   <= 1'b0;
      out_sum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a <= in_a;
            sh_b <= in_b;
          end
        end
        CLEAR: begin
          ser_a <= sh_a[0];
          ser_b <= sh_b[0];
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          cnt   <= '0;
        end
        SHIFT: begin
          acc <= acc_nxt;
          if (cnt == LAST) begin
            ser_a   <= 1'b0;
            ser_b   <= 1'b0;
            cnt     <= '0;
            out_sum <= acc_nxt;
          end else begin
            ser_a <= sh_a[0];
            ser_b <= sh_b[0];
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - scoreboard bench with a behavioural serial adder downstream
module tb_serial_add_sequencer;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
  } op_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       ser_clr;
  logic       ser_a;
  logic       ser_b;
  logic       ser_sum;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       carry;

  op_t        op_q[$];
  int         hs_log[$];
  op_t        exp_op;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_hs = 0;
  int         clr_cnt = 0;
  int         bitk = 0;
  int         c0;
  bit         collecting = 0;
  bit         prev_valid = 0;
  bit         prev_accept = 0;
  logic [7:0] abits;
  logic [7:0] bbits;
  logic [7:0] held_sum;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .ser_clr   (ser_clr),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_sum   (ser_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  // Downstream serial full adder with synchronous carry clear.
  always @(posedge clk or negedge rst) begin
    if (!rst) carry <= 1'b0;
    else if (ser_clr) carry <= 1'b0;
    else carry <= (ser_a & ser_b) | (carry & (ser_a ^ ser_b));
  end
  assign ser_sum = ser_a ^ ser_b ^ carry;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s);
    op_t o;
    int  n;
    o.a = a;
    o.b = b;
    o.sum = s;
    op_q.push_back(o);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (op_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (op_q.size() != 0) begin
      check("result_timeout", op_q.size(), 0);
      op_q.delete();
    end
  endtask

  // Monitor: serial streams, handshake timing and result scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      collecting  = 0;
      prev_valid  = 0;
      prev_accept = 0;
      check("rst_out_valid", out_valid, 0);
    end else begin
      if (prev_accept) check("idle_after_accept", {in_ready, out_valid}, 2'b10);
      if (collecting) begin
        abits[bitk] = ser_a;
        bbits[bitk] = ser_b;
        bitk++;
        check("clr_in_shift", ser_clr, 0);
        if (bitk == WIDTH) begin
          collecting = 0;
          if (op_q.size() == 0) begin
            check("ser_stream_without_op", 0, 1);
          end else begin
            check("ser_a_stream", abits, op_q[0].a);
            check("ser_b_stream", bbits, op_q[0].b);
          end
        end
      end else if (ser_clr) begin
        clr_cnt++;
        check("clr_ser_zero", {ser_a, ser_b}, 0);
        collecting = 1;
        bitk = 0;
      end else begin
        check("ser_idle_zero", {ser_a, ser_b}, 0);
      end
      if (in_valid && in_ready) begin
        last_hs = cyc;
        hs_log.push_back(cyc);
      end
      if (out_valid) begin
        check("in_ready_in_done", in_ready, 0);
        if (!prev_valid) check("latency", cyc - last_hs, WIDTH + 2);
        else check("held_sum", out_sum, held_sum);
        held_sum = out_sum;
        if (out_ready) begin
          if (op_q.size() == 0) begin
            check("unexpected_result", 0, 1);
          end else begin
            exp_op = op_q.pop_front();
            check("out_sum", out_sum, exp_op.sum);
          end
        end
      end
      prev_valid  = out_valid && !out_ready;
      prev_accept = out_valid && out_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #1;
    check("reset_state", {in_ready, ser_clr, ser_a, ser_b, out_valid}, 5'b10000);
    check("reset_out_sum", out_sum, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    tick();

    c0 = clr_cnt;
    send(8'h35, 8'h4A, 8'h7F);
    wait_empty();
    check("one_clr_pulse", clr_cnt - c0, 1);

    send(8'hFF, 8'h01, 8'h00);
    wait_empty();
    send(8'h80, 8'h80, 8'h00);
    wait_empty();
    send(8'hFF, 8'hFF, 8'hFE);
    wait_empty();

    // Abort at SHIFT bit 3, then the first op after release must complete normally.
    send(8'h5A, 8'h0F, 8'h69);
    repeat (4) tick();
    check("sum_held_in_shift", out_sum, 8'hFE);
    rst = 1'b0;
    #1;
    check("abort_state", {in_ready, ser_clr, ser_a, ser_b, out_valid}, 5'b10000);
    check("abort_out_sum", out_sum, 8'h00);
    op_q.delete();
    tick();
    tick();
    rst = 1'b1;
    send(8'h12, 8'h34, 8'h46);
    wait_empty();

    send(8'h0F, 8'h01, 8'h10);
    repeat (2) tick();
    in_a = 8'hAA;
    in_b = 8'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_empty();

    out_ready = 1'b0;
    send(8'h55, 8'h11, 8'h66);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_reached_done", out_valid, 1);
    repeat (5) tick();
    check("bp_still_waiting", {out_valid, in_ready}, 2'b10);
    check("bp_sum", out_sum, 8'h66);
    out_ready = 1'b1;
    tick();
    check("bp_released", {out_valid, in_ready}, 2'b01);
    check("bp_sum_held_idle", out_sum, 8'h66);
    wait_empty();

    hs_log.delete();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op_t o;
      case (i)
        0: o = {8'h01, 8'h02, 8'h03};
        1: o = {8'h7F, 8'h01, 8'h80};
        default: o = {8'hC3, 8'h3C, 8'hFF};
      endcase
      op_q.push_back(o);
      in_a = o.a;
      in_b = o.b;
      n = 0;
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      tick();
    end
    in_valid = 1'b0;
    wait_empty();
    check("b2b_handshakes", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      check("b2b_gap0", hs_log[1] - hs_log[0], WIDTH + 3);
      check("b2b_gap1", hs_log[2] - hs_log[1], WIDTH + 3);
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 SHALL take parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-007 SHALL have port in_a, input, WIDTH bits: operand A.
REQ-008 SHALL have port in_b, input, WIDTH bits: operand B.
REQ-009 SHALL have port ser_clr, output, 1 bit: carry-clear strobe to the downstream serial adder's synchronous clear input.
REQ-010 SHALL have port ser_a, output, 1 bit: operand A bit stream, LSB first.
REQ-011 SHALL have port ser_b, output, 1 bit: operand B bit stream, LSB first.
REQ-012 SHALL have port ser_sum, input, 1 bit: combinational sum bit returned by the serial adder.
REQ-013 SHALL have port out_valid, output, 1 bit: result available.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-015 SHALL have port out_sum, output, WIDTH bits: (in_a + in_b) mod 2^WIDTH.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, CLEAR, SHIFT, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; input handshake = in_valid & in_ready at a rising edge.
REQ-018 On handshake: in_a and in_b SHALL be captured into shift registers; next state CLEAR.
REQ-019 in_valid outside IDLE SHALL be ignored; the in_a/in_b values SHALL not be sampled.
REQ-020 CLEAR SHALL last exactly 1 cycle with ser_clr=1, ser_a=0, ser_b=0; next state SHIFT.
REQ-021 ser_clr SHALL be 0 in every state other than CLEAR.
REQ-022 SHIFT SHALL last exactly WIDTH cycles; in cycle k (k=0..WIDTH-1), ser_a/ser_b SHALL equal bit k of the captured operands.
REQ-023 ser_a/ser_b SHALL be registered outputs driven directly from shift-register bit 0.
REQ-024 ser_a and ser_b SHALL be 0 outside SHIFT.
REQ-025 In SHIFT cycle k, ser_sum SHALL be sampled at the closing edge into result bit k via a right-shift accumulator.
REQ-026 A bit counter SHALL end SHIFT after bit WIDTH-1; it SHALL not wrap or carry into another frame.
REQ-027 After the last SHIFT edge, state SHALL be DONE with out_valid=1 and out_sum stable.
REQ-028 Latency from the input-handshake edge to the first out_valid cycle SHALL be WIDTH+2 cycles.
REQ-029 DONE SHALL hold out_valid and out_sum until an edge with out_ready=1; next state IDLE.
REQ-030 Accept-to-accept throughput SHALL be at most one operation per WIDTH+3 cycles.
REQ-031 out_sum SHALL hold its last value in IDLE, CLEAR and SHIFT; out_valid SHALL be 0 there.
REQ-032 Carry-out SHALL be discarded; the result is modulo 2^WIDTH.
REQ-033 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-034 When rst=0, the block SHALL go asynchronously to IDLE with the state below, independent of clk.
REQ-035 Reset state: in_ready=1, ser_clr=0, ser_a=0, ser_b=0, out_valid=0, out_sum=0, counter=0, shift registers=0.
REQ-036 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no partial result SHALL be presented.
REQ-037 The first handshake after rst returns to 1 SHALL take effect at the first rising edge with rst=1.

Verification (WIDTH=8, bench models the serial adder downstream)
REQ-038 Basic add: in_a=0x35, in_b=0x4A -> exactly one ser_clr pulse, then ser_a = 1,0,1,0,1,1,0,0; out_valid 10 cycles after the handshake; out_sum=0x7F.
REQ-039 Wrap-around: in_a=0xFF, in_b=0x01 -> out_sum=0x00. Then in_a=0x80, in_b=0x80 -> out_sum=0x00. Then 0xFF+0xFF -> out_sum=0xFE.
REQ-040 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stay constant and in_ready stays 0; out_ready=1 -> IDLE on the next edge.
REQ-041 Busy input: pulse in_valid with in_a=0xAA during SHIFT -> no effect on the current frame; result unchanged.
REQ-042 Reset mid-operation: assert rst low at SHIFT bit 3 -> all outputs at reset values immediately; next op 0x12+0x34 -> out_sum=0x46.
REQ-043 Back-to-back: 3 ops with in_valid and out_ready held high -> handshakes exactly WIDTH+3 cycles apart; results correct and in order.
